// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR generator.
//   - lfsr_mode_e  : feedback structure (Fibonacci / Galois)
//   - DEF_TAPS_<n> : primitive feedback masks, bit i = x^(i+1) term
//   - lfsr_step    : one LFSR step on a zero-extended 32-bit state
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_e;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [3:0]  DEF_TAPS_4  = 4'hC;
  localparam logic [4:0]  DEF_TAPS_5  = 5'h14;
  localparam logic [5:0]  DEF_TAPS_6  = 6'h30;
  localparam logic [6:0]  DEF_TAPS_7  = 7'h60;
  localparam logic [7:0]  DEF_TAPS_8  = 8'hB8;
  localparam logic [8:0]  DEF_TAPS_9  = 9'h110;
  localparam logic [9:0]  DEF_TAPS_10 = 10'h240;
  localparam logic [10:0] DEF_TAPS_11 = 11'h500;
  localparam logic [11:0] DEF_TAPS_12 = 12'h829;
  localparam logic [12:0] DEF_TAPS_13 = 13'h100D;
  localparam logic [13:0] DEF_TAPS_14 = 14'h2015;
  localparam logic [14:0] DEF_TAPS_15 = 15'h6000;
  localparam logic [15:0] DEF_TAPS_16 = 16'hD008;
  localparam logic [16:0] DEF_TAPS_17 = 17'h12000;
  localparam logic [17:0] DEF_TAPS_18 = 18'h20400;
  localparam logic [18:0] DEF_TAPS_19 = 19'h40023;
  localparam logic [19:0] DEF_TAPS_20 = 20'h90000;
  localparam logic [20:0] DEF_TAPS_21 = 21'h140000;
  localparam logic [21:0] DEF_TAPS_22 = 22'h300000;
  localparam logic [22:0] DEF_TAPS_23 = 23'h420000;
  localparam logic [23:0] DEF_TAPS_24 = 24'hE10000;
  localparam logic [24:0] DEF_TAPS_25 = 25'h1200000;
  localparam logic [25:0] DEF_TAPS_26 = 26'h2000023;
  localparam logic [26:0] DEF_TAPS_27 = 27'h4000013;
  localparam logic [27:0] DEF_TAPS_28 = 28'h9000000;
  localparam logic [28:0] DEF_TAPS_29 = 29'h14000000;
  localparam logic [29:0] DEF_TAPS_30 = 30'h20000029;
  localparam logic [30:0] DEF_TAPS_31 = 31'h48000000;
  localparam logic [31:0] DEF_TAPS_32 = 32'h80200003;

  // State and taps are zero-extended to MAX_WIDTH; the Fibonacci shift-in
  // is masked back to 'width' bits, the Galois right shift never grows.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s,
                                            input logic [31:0] taps,
                                            input int unsigned width,
                                            input lfsr_mode_e  mode);
    logic [31:0] mask;
    mask = (width >= MAX_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
    if (mode == MODE_FIB) begin
      lfsr_step = ((s << 1) | {31'd0, ^(s & taps)}) & mask;
    end else begin
      lfsr_step = (s >> 1) ^ (s[0] ? taps : '0);
    end
  endfunction

endpackage

// File: rtl/lfsr_step_chain.sv
// lfsr_step_chain: combinational chain of SPC LFSR steps.
//   state_i : current state        mode_i  : feedback structure
//   seed_i  : stored seed          next_o  : state after SPC steps
//   match_o : bit k-1 set when intermediate state k equals seed_i
module lfsr_step_chain
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter int unsigned      SPC   = 1
) (
  input  logic [WIDTH-1:0] state_i,
  input  lfsr_mode_e       mode_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] next_o,
  output logic [SPC-1:0]   match_o
);

  logic [WIDTH-1:0] stage [SPC+1];
  logic [31:0]      step_w;

  always_comb begin
    step_w   = '0;
    match_o  = '0;
    stage[0] = state_i;
    for (int unsigned k = 1; k <= SPC; k++) begin
      step_w       = lfsr_step(32'(stage[k-1]), 32'(TAPS), WIDTH, mode_i);
      stage[k]     = step_w[WIDTH-1:0];
      match_o[k-1] = (stage[k] == seed_i);
    end
    next_o = stage[SPC];
  end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR pseudo-random generator.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   load       : capture seed/mode (zero seed replaced by 1)
//   seed, mode : seed value and feedback structure, sampled on load
//   en         : advance SPC steps this cycle (load has priority)
//   state      : registered LFSR state
//   bit_out    : MSB (Fibonacci) or LSB (Galois) of state
//   wrap       : pulse when the sequence returns to the stored seed
//   cycles     : enabled cycles since last load/wrap
//   seed_fix   : pulse when a zero seed was replaced
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter int unsigned      SPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] cycles,
  output logic             seed_fix
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] seed_q,   seed_d;
  lfsr_mode_e       mode_q,   mode_d;
  logic [WIDTH-1:0] cycles_q, cycles_d;
  logic             wrap_q,   wrap_d;
  logic             seed_fix_q, seed_fix_d;

  logic [WIDTH-1:0] chain_next;
  logic [SPC-1:0]   chain_match;

  lfsr_step_chain #(
    .WIDTH(WIDTH),
    .TAPS (TAPS),
    .SPC  (SPC)
  ) u_chain (
    .state_i(state_q),
    .mode_i (mode_q),
    .seed_i (seed_q),
    .next_o (chain_next),
    .match_o(chain_match)
  );

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    mode_d     = mode_q;
    cycles_d   = cycles_q;
    wrap_d     = 1'b0;
    seed_fix_d = 1'b0;
    if (load) begin
      if (seed == '0) begin
        state_d    = ONE;
        seed_d     = ONE;
        seed_fix_d = 1'b1;
      end else begin
        state_d = seed;
        seed_d  = seed;
      end
      mode_d   = lfsr_mode_e'(mode);
      cycles_d = '0;
    end else if (en) begin
      if (state_q == '0) begin
        // Lock-up escape: all-zero state would otherwise stick forever.
        state_d  = ONE;
        cycles_d = cycles_q + ONE;
      end else begin
        state_d  = chain_next;
        wrap_d   = |chain_match;
        cycles_d = (|chain_match) ? '0 : cycles_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ONE;
      seed_q     <= ONE;
      mode_q     <= MODE_FIB;
      cycles_q   <= '0;
      wrap_q     <= 1'b0;
      seed_fix_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      mode_q     <= mode_d;
      cycles_q   <= cycles_d;
      wrap_q     <= wrap_d;
      seed_fix_q <= seed_fix_d;
    end
  end

  assign state    = state_q;
  assign cycles   = cycles_q;
  assign wrap     = wrap_q;
  assign seed_fix = seed_fix_q;
  assign bit_out  = (mode_q == MODE_FIB) ? state_q[WIDTH-1] : state_q[0];

endmodule
